dt_dispense: RTL and testbench
==============================

# dt_dispense

Downstream stage of the metro ticket vending controller. It takes one completed sale (ticket count plus change owed) through a valid/ready handshake. It then drives the ticket dispenser and the 5-yuan and 1-yuan coin hoppers one item at a time, confirming each drop with a sensor edge. It reports what was actually issued and any fault.

## Interface
- `PULSE_CYCLES`, default 4: width of each drive pulse in clock cycles; minimum 1.
- `TIMEOUT_CYCLES`, default 1000: maximum cycles from drive start to drop-sensor edge; must be greater than `PULSE_CYCLES`.
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `req_valid`, in, 1: sale request present.
- `req_ready`, out, 1: block idle and able to accept a request.
- `req_tickets`, in, 2: tickets to issue (0–3).
- `req_change`, in, 8: change to pay in yuan (0–255).
- `tkt_drive`, out, 1: ticket dispenser drive pulse.
- `tkt_sense`, in, 1: ticket drop sensor; asynchronous.
- `c5_drive` / `c1_drive`, out, 1 each: hopper drive pulses.
- `c5_sense` / `c1_sense`, in, 1 each: coin drop sensors; asynchronous.
- `c5_empty` / `c1_empty`, in, 1 each: hopper empty level; treated as quasi-static and not synchronized.
- `busy`, out, 1: request in progress.
- `done`, out, 1: one-cycle completion pulse.
- `fault`, out, 2: fault code. 0 = none, 1 = ticket timeout, 2 = coin timeout, 3 = hopper empty.
- `tickets_out`, out, 2: tickets actually issued.
- `paid_change`, out, 8: yuan actually paid.

## Operation
- Reset values:
  - `req_ready` = 1.
  - Every other output = 0.
  - State = IDLE; all counters cleared.
- **Accept.** A request is accepted on a rising edge where `req_valid && req_ready`.
  - `req_tickets` and `req_change` are latched into `tkt_left` and `chg_left`.
  - `fault`, `tickets_out` and `paid_change` are cleared.
- **States:** IDLE, SELECT, DRIVE, WAIT, DONE.
- **SELECT** chooses the next item, in this priority order:
  - `tkt_left != 0` → ticket.
  - else `chg_left >= 5` and `!c5_empty` → 5-yuan coin.
  - else `chg_left != 0` and `!c1_empty` → 1-yuan coin.
  - else `chg_left != 0` (the needed hopper is empty) → `fault` = 3, go to DONE.
  - else (nothing left) → DONE.
  - When `c5_empty` is set, 5-yuan amounts are paid in 1-yuan coins.
- **DRIVE.** The selected drive output is high for exactly `PULSE_CYCLES` cycles.
  - An item timer starts at 0 on the first drive cycle.
- **WAIT.** The block waits for the selected sensor edge or for the timer to reach `TIMEOUT_CYCLES`.
- **Drop edge.** A synchronized rising edge of the selected sensor, seen in DRIVE or WAIT, confirms the drop.
  - The edge is latched; DRIVE still completes its full pulse.
  - Then go to SELECT.
  - Ticket drop: `tkt_left` −1, `tickets_out` +1.
  - Coin drop: `chg_left` minus the coin value, `paid_change` plus the coin value.
  - `chg_left` never underflows, because selection guarantees the coin value ≤ `chg_left`.
- **Timeout.** `fault` = 1 (ticket) or 2 (coin), then DONE. No further items are issued.
- **Ignored edges.** Sensor edges on non-selected sensors, or in IDLE, SELECT or DONE, are ignored.
- **DONE.** `done` = 1 for one cycle, then IDLE.
- **Result hold.** `fault`, `tickets_out` and `paid_change` hold until the next accept.
- `busy` = (state != IDLE).
- `req_ready` = (state == IDLE).

## Timing
- Each sensor goes through a 2-flop synchronizer plus a rising-edge detect, so an edge is recognized 3 cycles after the pin rises.
- Zero request (`req_tickets` = 0, `req_change` = 0), accepted at edge T:
  - SELECT at T+1.
  - DONE at T+2, with `done` high in that cycle.
  - `req_ready` high again at T+3.
- The item timer is a full-width counter sized for `TIMEOUT_CYCLES` and saturates.
  - Timeout fires in the cycle where the timer equals `TIMEOUT_CYCLES` − 1 with no edge seen.
- A sensor edge in the same cycle as the timeout wins: the drop is counted and no fault is raised.
- `req_valid` while busy is not accepted; the request is held by upstream.
- `rst_n` low at any time, including mid-DRIVE:
  - All drives drop immediately (asynchronously).
  - The partial sale is discarded.
  - No `done` is generated.
- Drive outputs are registered and glitch-free.

## Structure
- Package `dt_pkg`:
  - State enum.
  - Fault code constants: `FLT_NONE`, `FLT_TKT_TO`, `FLT_COIN_TO`, `FLT_EMPTY`.
  - Coin value constants: `COIN5` = 5, `COIN1` = 1.
  - Item-select enum: TKT, C5, C1.
- Sub-module `dt_sense_sync` (2-flop synchronizer plus rising-edge pulse), instantiated three times.
- All other logic lives in `dt_dispense`.

## Test plan
Bench parameters: `PULSE_CYCLES` = 4, `TIMEOUT_CYCLES` = 16; the sensor model responds 2 cycles after drive rises.
- **Reset, then zero request.**
  - All outputs 0 and `req_ready` = 1 after reset.
  - Zero request → `done` at T+2; `fault` = 0, `tickets_out` = 0, `paid_change` = 0.
- **Normal sale: tickets = 2, change = 7.**
  - Drive sequence: 2 `tkt_drive` pulses, then 1 `c5_drive`, then 2 `c1_drive`, each exactly 4 cycles wide.
  - Result: `done`, `tickets_out` = 2, `paid_change` = 7, `fault` = 0.
- **5-yuan hopper empty: change = 10, `c5_empty` = 1.**
  - Exactly 10 `c1_drive` pulses.
  - Result: `paid_change` = 10, `fault` = 0.
- **Ticket timeout: tickets = 1, change = 3, ticket sensor never fires.**
  - `fault` = 1, 16 cycles after drive start.
  - `tickets_out` = 0, `paid_change` = 0, and no coin drive occurs.
- **1-yuan hopper empties mid-sale: change = 3.**
  - `c1_empty` rises after the first coin.
  - Result: `fault` = 3, `paid_change` = 1, `done` pulses once.
- **Reset mid-sale.**
  - `rst_n` pulsed low during the second `c1_drive` of a change = 7 request.
  - Drive drops in the same cycle, no `done`, all outputs 0, `req_ready` = 1 after release.
  - A new request then completes normally.

Source files
------------

// File: rtl/dt_pkg.sv
// rtl/dt_pkg.sv - shared types and constants for the ticket/coin dispense stage
package dt_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_DRIVE,
        S_WAIT,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        ITEM_TKT,
        ITEM_C5,
        ITEM_C1
    } item_t;

    localparam logic [1:0] FLT_NONE    = 2'd0;
    localparam logic [1:0] FLT_TKT_TO  = 2'd1;
    localparam logic [1:0] FLT_COIN_TO = 2'd2;
    localparam logic [1:0] FLT_EMPTY   = 2'd3;

    localparam logic [7:0] COIN5 = 8'd5;
    localparam logic [7:0] COIN1 = 8'd1;

endpackage

// File: rtl/dt_sense_sync.sv
// rtl/dt_sense_sync.sv - 2-flop synchronizer plus rising-edge pulse for a drop sensor
module dt_sense_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic sense_i,
    output logic rise_o
);

    // [0],[1] form the synchronizer; [2] is the previous synchronized level
    logic [2:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 3'b000;
        end else begin
            sync_q <= {sync_q[1:0], sense_i};
        end
    end

    assign rise_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/dt_dispense.sv
// rtl/dt_dispense.sv - issues tickets and change one item at a time, confirming each drop
module dt_dispense
    import dt_pkg::*;
#(
    parameter int PULSE_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_tickets,
    input  logic [7:0] req_change,
    output logic       tkt_drive,
    input  logic       tkt_sense,
    output logic       c5_drive,
    input  logic       c5_sense,
    output logic       c1_drive,
    input  logic       c1_sense,
    input  logic       c5_empty,
    input  logic       c1_empty,
    output logic       busy,
    output logic       done,
    output logic [1:0] fault,
    output logic [1:0] tickets_out,
    output logic [7:0] paid_change
);

    localparam int PW = $clog2(PULSE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_CYCLES - 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TIMER_MAX  = TW'(TIMEOUT_CYCLES);

    state_t          state_q, state_d;
    item_t           item_q, item_d;
    logic [1:0]      tkt_left_q, tkt_left_d;
    logic [7:0]      chg_left_q, chg_left_d;
    logic [1:0]      tickets_out_q, tickets_out_d;
    logic [7:0]      paid_change_q, paid_change_d;
    logic [1:0]      fault_q, fault_d;
    logic [PW-1:0]   pulse_q, pulse_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            edge_seen_q, edge_seen_d;
    logic [2:0]      drive_q, drive_d;
    logic            tkt_rise, c5_rise, c1_rise;
    logic            sel_rise;
    logic            credit;
    logic [7:0]      coin_val;

    dt_sense_sync u_tkt_sync (.clk(clk), .rst_n(rst_n), .sense_i(tkt_sense), .rise_o(tkt_rise));
    dt_sense_sync u_c5_sync  (.clk(clk), .rst_n(rst_n), .sense_i(c5_sense),  .rise_o(c5_rise));
    dt_sense_sync u_c1_sync  (.clk(clk), .rst_n(rst_n), .sense_i(c1_sense),  .rise_o(c1_rise));

    always_comb begin
        sel_rise = 1'b0;
        case (item_q)
            ITEM_TKT: sel_rise = tkt_rise;
            ITEM_C5:  sel_rise = c5_rise;
            ITEM_C1:  sel_rise = c1_rise;
            default:  sel_rise = 1'b0;
        endcase
    end

    assign coin_val = (item_q == ITEM_C5) ? COIN5 : COIN1;

    always_comb begin
        state_d       = state_q;
        item_d        = item_q;
        tkt_left_d    = tkt_left_q;
        chg_left_d    = chg_left_q;
        tickets_out_d = tickets_out_q;
        paid_change_d = paid_change_q;
        fault_d       = fault_q;
        pulse_d       = pulse_q;
        timer_d       = timer_q;
        edge_seen_d   = edge_seen_q;
        drive_d       = drive_q;
        credit        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    tkt_left_d    = req_tickets;
                    chg_left_d    = req_change;
                    tickets_out_d = 2'd0;
                    paid_change_d = 8'd0;
                    fault_d       = FLT_NONE;
                    state_d       = S_SELECT;
                end
            end
            S_SELECT: begin
                pulse_d     = '0;
                timer_d     = '0;
                edge_seen_d = 1'b0;
                if (tkt_left_q != 2'd0) begin
                    item_d  = ITEM_TKT;
                    drive_d = 3'b001;
                    state_d = S_DRIVE;
                end else if (chg_left_q >= COIN5 && !c5_empty) begin
                    item_d  = ITEM_C5;
                    drive_d = 3'b010;
                    state_d = S_DRIVE;
                end else if (chg_left_q != 8'd0 && !c1_empty) begin
                    item_d  = ITEM_C1;
                    drive_d = 3'b100;
                    state_d = S_DRIVE;
                end else if (chg_left_q != 8'd0) begin
                    fault_d = FLT_EMPTY;
                    state_d = S_DONE;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DRIVE: begin
                timer_d = (timer_q == TIMER_MAX) ? timer_q : timer_q + TW'(1);
                pulse_d = pulse_q + PW'(1);
                if (sel_rise) begin
                    edge_seen_d = 1'b1;
                end
                // An early edge is remembered; the pulse always runs to full width
                if (pulse_q == PULSE_LAST) begin
                    drive_d = 3'b000;
                    if (edge_seen_q || sel_rise) begin
                        credit  = 1'b1;
                        state_d = S_SELECT;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                timer_d = (timer_q == TIMER_MAX) ? timer_q : timer_q + TW'(1);
                if (sel_rise) begin
                    credit  = 1'b1;
                    state_d = S_SELECT;
                end else if (timer_q == TIMER_LAST) begin
                    fault_d = (item_q == ITEM_TKT) ? FLT_TKT_TO : FLT_COIN_TO;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (credit) begin
            if (item_q == ITEM_TKT) begin
                tkt_left_d    = tkt_left_q - 2'd1;
                tickets_out_d = tickets_out_q + 2'd1;
            end else begin
                chg_left_d    = chg_left_q - coin_val;
                paid_change_d = paid_change_q + coin_val;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            item_q        <= ITEM_TKT;
            tkt_left_q    <= 2'd0;
            chg_left_q    <= 8'd0;
            tickets_out_q <= 2'd0;
            paid_change_q <= 8'd0;
            fault_q       <= FLT_NONE;
            pulse_q       <= '0;
            timer_q       <= '0;
            edge_seen_q   <= 1'b0;
            drive_q       <= 3'b000;
        end else begin
            state_q       <= state_d;
            item_q        <= item_d;
            tkt_left_q    <= tkt_left_d;
            chg_left_q    <= chg_left_d;
            tickets_out_q <= tickets_out_d;
            paid_change_q <= paid_change_d;
            fault_q       <= fault_d;
            pulse_q       <= pulse_d;
            timer_q       <= timer_d;
            edge_seen_q   <= edge_seen_d;
            drive_q       <= drive_d;
        end
    end

    assign tkt_drive   = drive_q[0];
    assign c5_drive    = drive_q[1];
    assign c1_drive    = drive_q[2];
    assign req_ready   = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign fault       = fault_q;
    assign tickets_out = tickets_out_q;
    assign paid_change = paid_change_q;

endmodule

// File: tb/tb_dt_dispense.sv
// tb/tb_dt_dispense.sv - directed self-checking bench for dt_dispense
module tb_dt_dispense;

    localparam int PULSE = 4;
    localparam int TMO   = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [1:0] req_tickets = 2'd0;
    logic [7:0] req_change = 8'd0;
    logic       tkt_drive, c5_drive, c1_drive;
    logic       tkt_sense = 1'b0, c5_sense = 1'b0, c1_sense = 1'b0;
    logic       c5_empty = 1'b0, c1_empty = 1'b0;
    logic       busy, done;
    logic [1:0] fault, tickets_out;
    logic [7:0] paid_change;

    dt_dispense #(.PULSE_CYCLES(PULSE), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_tickets(req_tickets), .req_change(req_change),
        .tkt_drive(tkt_drive), .tkt_sense(tkt_sense),
        .c5_drive(c5_drive), .c5_sense(c5_sense),
        .c1_drive(c1_drive), .c1_sense(c1_sense),
        .c5_empty(c5_empty), .c1_empty(c1_empty),
        .busy(busy), .done(done), .fault(fault),
        .tickets_out(tickets_out), .paid_change(paid_change)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // drive monitor (item codes 0=ticket 1=c5 2=c1) and sensor model
    int       seq[$];
    int       width[3];
    int       bad_width = 0;
    int       done_cnt = 0;
    int       last_rise_cyc = 0;
    logic [2:0] prev_drv = 3'b000;
    logic [2:0] drv;
    int       tkt_cnt = 0, c5_cnt = 0, c1_cnt = 0;
    logic     tkt_en = 1'b1;

    always @(negedge clk) begin
        drv = {c1_drive, c5_drive, tkt_drive};
        for (int k = 0; k < 3; k++) begin
            if (drv[k] && !prev_drv[k]) begin
                width[k] = 1;
                seq.push_back(k);
                last_rise_cyc = cyc;
            end else if (drv[k]) begin
                width[k]++;
            end else if (prev_drv[k] && width[k] != PULSE) begin
                bad_width++;
            end
        end
        prev_drv = drv;
        if (done) done_cnt++;
        tkt_cnt = tkt_drive ? tkt_cnt + 1 : 0;
        c5_cnt  = c5_drive  ? c5_cnt + 1  : 0;
        c1_cnt  = c1_drive  ? c1_cnt + 1  : 0;
        tkt_sense = tkt_en && (tkt_cnt == 2 || tkt_cnt == 3);
        c5_sense  = (c5_cnt == 2 || c5_cnt == 3);
        c1_sense  = (c1_cnt == 2 || c1_cnt == 3);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_req(input int t, input int c);
        @(negedge clk);
        req_valid   = 1'b1;
        req_tickets = 2'(t);
        req_change  = 8'(c);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int maxc);
        int n;
        n = 0;
        while (!done && n < maxc) begin
            @(negedge clk);
            #1;
            n++;
        end
        check({tag, "_done_seen"}, int'(done), 1);
    endtask

    function automatic int count_item(input int from, input int item);
        int n;
        n = 0;
        for (int k = from; k < seq.size(); k++) if (seq[k] == item) n++;
        return n;
    endfunction

    int s0, bw0, dc0, rise0, got;
    int exp_seq[5] = '{0, 0, 1, 2, 2};

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // reset
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_ready", int'(req_ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_fault", int'(fault), 0);
        check("rst_tickets", int'(tickets_out), 0);
        check("rst_paid", int'(paid_change), 0);
        check("rst_drives", int'({tkt_drive, c5_drive, c1_drive}), 0);

        // zero request: SELECT after T, DONE after T+1, ready after T+2
        start_req(0, 0);
        check("zero_busy", int'(busy), 1);
        check("zero_ready_low", int'(req_ready), 0);
        check("zero_done_early", int'(done), 0);
        step();
        check("zero_done", int'(done), 1);
        check("zero_fault", int'(fault), 0);
        check("zero_tickets", int'(tickets_out), 0);
        check("zero_paid", int'(paid_change), 0);
        step();
        check("zero_ready_again", int'(req_ready), 1);
        check("zero_done_gone", int'(done), 0);

        // normal sale 2 tickets, 7 yuan
        s0 = seq.size(); bw0 = bad_width; dc0 = done_cnt;
        start_req(2, 7);
        wait_done("sale", 300);
        check("sale_tickets", int'(tickets_out), 2);
        check("sale_paid", int'(paid_change), 7);
        check("sale_fault", int'(fault), 0);
        step();
        check("sale_items", seq.size() - s0, 5);
        for (int k = 0; k < 5; k++) begin
            got = (s0 + k < seq.size()) ? seq[s0 + k] : -1;
            check($sformatf("sale_item%0d", k), got, exp_seq[k]);
        end
        check("sale_widths", bad_width - bw0, 0);
        check("sale_done_once", done_cnt - dc0, 1);
        check("sale_hold_paid", int'(paid_change), 7);

        // 5-yuan hopper empty: 10 yuan paid in ones
        c5_empty = 1'b1;
        s0 = seq.size(); bw0 = bad_width;
        start_req(0, 10);
        wait_done("c5e", 400);
        check("c5e_paid", int'(paid_change), 10);
        check("c5e_fault", int'(fault), 0);
        check("c5e_c1_pulses", count_item(s0, 2), 10);
        check("c5e_total_pulses", seq.size() - s0, 10);
        check("c5e_widths", bad_width - bw0, 0);
        step();
        c5_empty = 1'b0;

        // ticket timeout
        tkt_en = 1'b0;
        s0 = seq.size();
        start_req(1, 3);
        wait_done("tto", 200);
        rise0 = last_rise_cyc;
        check("tto_fault", int'(fault), 1);
        check("tto_latency", cyc - rise0, TMO);
        check("tto_tickets", int'(tickets_out), 0);
        check("tto_paid", int'(paid_change), 0);
        step();
        check("tto_pulses", seq.size() - s0, 1);
        check("tto_no_coin", count_item(s0, 1) + count_item(s0, 2), 0);
        tkt_en = 1'b1;

        // 1-yuan hopper empties after first coin
        s0 = seq.size(); dc0 = done_cnt;
        start_req(0, 3);
        for (int n = 0; n < 100; n++) begin
            if (count_item(s0, 2) >= 1 && !c1_drive) break;
            @(negedge clk);
            #1;
        end
        c1_empty = 1'b1;
        wait_done("c1e", 200);
        check("c1e_fault", int'(fault), 3);
        check("c1e_paid", int'(paid_change), 1);
        repeat (3) step();
        check("c1e_done_once", done_cnt - dc0, 1);
        c1_empty = 1'b0;

        // reset during the second 1-yuan pulse of a 7-yuan sale
        s0 = seq.size(); dc0 = done_cnt;
        start_req(0, 7);
        for (int n = 0; n < 200; n++) begin
            if (count_item(s0, 2) >= 2 && c1_drive) break;
            @(negedge clk);
            #1;
        end
        check("mid_c1_active", int'(c1_drive), 1);
        rst_n = 1'b0;
        #1;
        check("mid_drive_drop", int'({tkt_drive, c5_drive, c1_drive}), 0);
        check("mid_ready", int'(req_ready), 1);
        check("mid_paid", int'(paid_change), 0);
        check("mid_fault", int'(fault), 0);
        repeat (2) step();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("mid_ready_after", int'(req_ready), 1);
        check("mid_busy_after", int'(busy), 0);
        check("mid_no_done", done_cnt - dc0, 0);
        start_req(1, 1);
        wait_done("post", 200);
        check("post_tickets", int'(tickets_out), 1);
        check("post_paid", int'(paid_change), 1);
        check("post_fault", int'(fault), 0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
